// File: rtl/n101_icb_pkg.sv
// rtl/n101_icb_pkg.sv - shared state encoding and default widths for the ICB responder
package n101_icb_pkg;

    localparam int DEF_AW   = 10;
    localparam int DEF_DW   = 32;
    localparam int DEF_XW   = 10;
    localparam int MAX_WAIT = 15;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_WAIT = WAIT,
        ST_RESP = RESP
    } state_e;

endpackage

// File: rtl/n101_icb_responder_if.sv
// rtl/n101_icb_responder_if.sv - request/response bundle between initiator and responder
interface n101_icb_responder_if
    import n101_icb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int XW = DEF_XW
);
    logic              io_req_valid;
    logic              io_req_ready;
    logic              io_req_bits_read;
    logic [AW-1:0]     io_req_bits_index;
    logic [DW-1:0]     io_req_bits_data;
    logic [DW/8-1:0]   io_req_bits_mask;
    logic [XW-1:0]     io_req_bits_extra;
    logic              io_rsp_valid;
    logic              io_rsp_ready;
    logic [DW-1:0]     io_rsp_bits_data;
    logic              io_rsp_bits_read;
    logic [XW-1:0]     io_rsp_bits_extra;
    logic              io_busy;

    modport master (
        output io_req_valid, io_req_bits_read, io_req_bits_index, io_req_bits_data,
               io_req_bits_mask, io_req_bits_extra, io_rsp_ready,
        input  io_req_ready, io_rsp_valid, io_rsp_bits_data, io_rsp_bits_read,
               io_rsp_bits_extra, io_busy
    );

    modport slave (
        input  io_req_valid, io_req_bits_read, io_req_bits_index, io_req_bits_data,
               io_req_bits_mask, io_req_bits_extra, io_rsp_ready,
        output io_req_ready, io_rsp_valid, io_rsp_bits_data, io_rsp_bits_read,
               io_rsp_bits_extra, io_busy
    );

endinterface

// File: rtl/n101_bytemask_ram.sv
// rtl/n101_bytemask_ram.sv - word array with synchronous read and byte-enabled write
module n101_bytemask_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic            clock,
    input  logic            en,
    input  logic            we,
    input  logic [AW-1:0]   index,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wmask,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] mem [2**AW];

    // Contents are deliberately not reset so data survives a responder reset;
    // rdata only moves on reads, so it stays put while a response is held.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DW/8; i++) begin
                    if (wmask[i]) begin
                        mem[index][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/n101_icb_responder.sv
// rtl/n101_icb_responder.sv - single-outstanding responder with wait states and byte-masked storage
module n101_icb_responder #(
    parameter int AW   = n101_icb_pkg::DEF_AW,
    parameter int DW   = n101_icb_pkg::DEF_DW,
    parameter int XW   = n101_icb_pkg::DEF_XW,
    parameter int WAIT = 0
) (
    input  logic               clock,
    input  logic               reset,
    n101_icb_responder_if.slave bus
);
    import n101_icb_pkg::state_e;
    import n101_icb_pkg::ST_IDLE;
    import n101_icb_pkg::ST_WAIT;
    import n101_icb_pkg::ST_RESP;

    localparam int MW = DW / 8;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    if (WAIT < 0 || WAIT > n101_icb_pkg::MAX_WAIT) begin : g_bad_wait
        $error("n101_icb_responder: WAIT must be in 0..15");
    end

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            req_read_q;
    logic [AW-1:0]   req_index_q;
    logic [DW-1:0]   req_data_q;
    logic [MW-1:0]   req_mask_q;
    logic [XW-1:0]   req_extra_q;
    logic            rsp_read_q;
    logic [XW-1:0]   rsp_extra_q;

    logic            req_ready, rsp_valid, req_fire, rsp_fire, access;
    logic            acc_read;
    logic [AW-1:0]   acc_index;
    logic [DW-1:0]   acc_data;
    logic [MW-1:0]   acc_mask;
    logic [XW-1:0]   acc_extra;
    logic [DW-1:0]   ram_rdata;

    // Handshakes; the only rsp_ready -> req_ready path is the single AND term.
    always_comb begin
        req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.io_rsp_ready);
        rsp_valid = (state_q == ST_RESP);
        req_fire  = bus.io_req_valid & req_ready;
        rsp_fire  = rsp_valid & bus.io_rsp_ready;
    end

    // With no wait states the access happens on the accept edge, so it must use
    // the live request; otherwise it uses the latched copy.
    always_comb begin
        acc_read  = (WAIT == 0) ? bus.io_req_bits_read  : req_read_q;
        acc_index = (WAIT == 0) ? bus.io_req_bits_index : req_index_q;
        acc_data  = (WAIT == 0) ? bus.io_req_bits_data  : req_data_q;
        acc_mask  = (WAIT == 0) ? bus.io_req_bits_mask  : req_mask_q;
        acc_extra = (WAIT == 0) ? bus.io_req_bits_extra : req_extra_q;
    end

    // Next state, wait counter and access strobe; a new acceptance overrides the
    // RESP->IDLE move so back-to-back requests behave exactly like ones from IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    access  = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (req_fire) begin
            if (WAIT == 0) begin
                state_d = ST_RESP;
                access  = 1'b1;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_CNT;
            end
        end
    end

    // State, counter, request latch and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_read_q  <= 1'b0;
            req_index_q <= '0;
            req_data_q  <= '0;
            req_mask_q  <= '0;
            req_extra_q <= '0;
            rsp_read_q  <= 1'b0;
            rsp_extra_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_fire) begin
                req_read_q  <= bus.io_req_bits_read;
                req_index_q <= bus.io_req_bits_index;
                req_data_q  <= bus.io_req_bits_data;
                req_mask_q  <= bus.io_req_bits_mask;
                req_extra_q <= bus.io_req_bits_extra;
            end
            if (access) begin
                rsp_read_q  <= acc_read;
                rsp_extra_q <= acc_extra;
            end
        end
    end

    // Reset blocks the access so a pending write never lands in the array.
    n101_bytemask_ram #(.AW(AW), .DW(DW)) u_ram (
        .clock (clock),
        .en    (access & ~reset),
        .we    (~acc_read),
        .index (acc_index),
        .wdata (acc_data),
        .wmask (acc_mask),
        .rdata (ram_rdata)
    );

    // Write responses and the reset state return zero data.
    always_comb begin
        bus.io_req_ready      = req_ready;
        bus.io_rsp_valid      = rsp_valid;
        bus.io_rsp_bits_data  = rsp_read_q ? ram_rdata : '0;
        bus.io_rsp_bits_read  = rsp_read_q;
        bus.io_rsp_bits_extra = rsp_extra_q;
        bus.io_busy           = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_n101_icb_responder.sv
// tb/tb_n101_icb_responder.sv - self-checking bench for n101_icb_responder at WAIT 0, 3 and 5
module tb_n101_icb_responder;

    typedef struct {
        logic        rd;
        logic [9:0]  idx;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [9:0]  extra;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_read, rsp_ready;
    logic [9:0]  req_index, req_extra;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic [1:0]  sel;

    logic        ready_a [3];
    logic        valid_a [3];
    logic        rread_a [3];
    logic        busy_a  [3];
    logic [31:0] data_a  [3];
    logic [9:0]  extra_a [3];

    logic        o_ready, o_valid, o_rread, o_busy;
    logic [31:0] o_data;
    logic [9:0]  o_extra;

    int checks = 0;
    int errors = 0;
    int wait_of [3] = '{0, 3, 5};
    logic [31:0] model [16];
    vec_t tbl [10];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
            n101_icb_responder_if #(.AW(10), .DW(32), .XW(10)) bus ();
            assign bus.io_req_valid      = req_valid && (sel == 2'(g));
            assign bus.io_req_bits_read  = req_read;
            assign bus.io_req_bits_index = req_index;
            assign bus.io_req_bits_data  = req_data;
            assign bus.io_req_bits_mask  = req_mask;
            assign bus.io_req_bits_extra = req_extra;
            assign bus.io_rsp_ready      = rsp_ready;
            assign ready_a[g] = bus.io_req_ready;
            assign valid_a[g] = bus.io_rsp_valid;
            assign rread_a[g] = bus.io_rsp_bits_read;
            assign busy_a[g]  = bus.io_busy;
            assign data_a[g]  = bus.io_rsp_bits_data;
            assign extra_a[g] = bus.io_rsp_bits_extra;
            n101_icb_responder #(.AW(10), .DW(32), .XW(10), .WAIT(W)) u_dut (
                .clock (clk),
                .reset (reset),
                .bus   (bus)
            );
        end
    endgenerate

    assign o_ready = ready_a[sel];
    assign o_valid = valid_a[sel];
    assign o_rread = rread_a[sel];
    assign o_busy  = busy_a[sel];
    assign o_data  = data_a[sel];
    assign o_extra = extra_a[sel];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One full transaction on the selected responder; called just after a rising edge.
    task automatic do_req(input logic rd, input logic [9:0] idx, input logic [31:0] wd,
                          input logic [3:0] m, input logic [9:0] x, input int bp,
                          output logic [31:0] d, output logic r, output logic [9:0] xo,
                          output int lat);
        int n = 0;
        logic [31:0] d0;
        req_read = rd; req_index = idx; req_data = wd; req_mask = m; req_extra = x;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        while (!o_ready && n < 20) begin @(negedge clk); n++; end
        if (!o_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", o_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!o_valid && lat < 30) begin
            checks++;
            if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_state: ready=%b busy=%b, required ready=0 busy=1", o_ready, o_busy);
            end
            lat++;
            @(negedge clk);
        end
        if (!o_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b, required 1", o_valid);
        end
        d0 = o_data;
        repeat (bp) @(negedge clk);
        if (bp > 0) check("hold_data", {32'd0, o_data}, {32'd0, d0});
        d = o_data; r = o_rread; xo = o_extra;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        r;
        logic [9:0]  x;
        int          lat;

        tbl[0] = '{1'b0, 10'd5,    32'hDEADBEEF, 4'hF, 10'h3A5, 32'h0};
        tbl[1] = '{1'b1, 10'd5,    32'h0,        4'hF, 10'h011, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 10'd5,    32'h11223344, 4'h5, 10'h022, 32'h0};
        tbl[3] = '{1'b1, 10'd5,    32'h0,        4'h0, 10'h033, 32'hDE22BE44};
        tbl[4] = '{1'b0, 10'd6,    32'hAABBCCDD, 4'hF, 10'h044, 32'h0};
        tbl[5] = '{1'b0, 10'd6,    32'h12345678, 4'h0, 10'h055, 32'h0};
        tbl[6] = '{1'b1, 10'd6,    32'h0,        4'h3, 10'h066, 32'hAABBCCDD};
        tbl[7] = '{1'b0, 10'd1023, 32'h01020304, 4'hF, 10'h3FF, 32'h0};
        tbl[8] = '{1'b0, 10'd1023, 32'hCAFEF00D, 4'h9, 10'h000, 32'h0};
        tbl[9] = '{1'b1, 10'd1023, 32'h0,        4'h0, 10'h1AB, 32'hCA02030D};

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; sel = 2'd0;
        req_read = 1'b0; req_index = '0; req_data = '0; req_mask = '0; req_extra = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s); #1;
            check("rst_ready", {63'd0, o_ready}, 64'd1);
            check("rst_valid", {63'd0, o_valid}, 64'd0);
            check("rst_busy",  {63'd0, o_busy},  64'd0);
            check("rst_fields", {21'd0, o_rread, o_extra, o_data}, 64'd0);
        end
        sel = 2'd0;
        @(posedge clk); #1;

        // Directed vectors on the zero-wait responder.
        for (int i = 0; i < 10; i++) begin
            do_req(tbl[i].rd, tbl[i].idx, tbl[i].data, tbl[i].mask, tbl[i].extra, 0, d, r, x, lat);
            check($sformatf("vec%0d_data", i), {32'd0, d}, {32'd0, tbl[i].exp});
            check($sformatf("vec%0d_read", i), {63'd0, r}, {63'd0, tbl[i].rd});
            check($sformatf("vec%0d_extra", i), {54'd0, x}, {54'd0, tbl[i].extra});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd0);
        end

        // Randomized traffic against a word-array reference model.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            do_req(1'b0, 10'(i), model[i], 4'hF, 10'(i), 0, d, r, x, lat);
            check("init_wr", {22'd0, x, d}, {22'd0, 10'(i), 32'd0});
        end
        for (int i = 0; i < 150; i++) begin
            logic        rd;
            logic [3:0]  idx, m;
            logic [31:0] wd;
            logic [9:0]  tag;
            logic [31:0] exp;
            rd  = 1'($urandom_range(1, 0));
            idx = 4'($urandom_range(15, 0));
            m   = 4'($urandom_range(15, 0));
            wd  = $urandom;
            tag = 10'($urandom_range(1023, 0));
            exp = rd ? model[idx] : 32'd0;
            if (!rd) model[idx] = merge(model[idx], wd, m);
            do_req(rd, {6'd0, idx}, wd, m, tag, int'($urandom_range(2, 0)), d, r, x, lat);
            check("rnd_rsp", {21'd0, r, x, d}, {21'd0, rd, tag, exp});
            check("rnd_lat", 64'(lat), 64'd0);
        end

        // Back-to-back reads of indices 0..3 with the response always accepted.
        rsp_ready = 1'b1;
        req_read = 1'b1; req_index = 10'd0; req_extra = 10'h200; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) check("b2b_idle", {63'd0, o_valid}, 64'd0);
            else check($sformatf("b2b_rsp%0d", k - 1), {22'd0, o_valid, o_extra, o_data[30:0]},
                       {22'd0, 1'b1, 10'h200 + 10'(k - 1), model[k - 1][30:0]});
            if (k < 4) check($sformatf("b2b_ready%0d", k), {63'd0, o_ready}, 64'd1);
            @(posedge clk); #1;
            if (k < 3) begin req_index = 10'(k + 1); req_extra = 10'h200 + 10'(k + 1); end
            else req_valid = 1'b0;
        end

        // WAIT=3: latency, then backpressure with a queued request.
        sel = 2'd1;
        do_req(1'b0, 10'd2, 32'h55AA55AA, 4'hF, 10'h0F0, 0, d, r, x, lat);
        check("w3_wr_lat", 64'(lat), 64'(wait_of[1]));
        req_read = 1'b1; req_index = 10'd2; req_extra = 10'h100; req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_accept", {63'd0, o_ready}, 64'd1);
        @(posedge clk); #1 req_extra = 10'h2BC;
        lat = 0;
        @(negedge clk);
        while (!o_valid && lat < 30) begin lat++; @(negedge clk); end
        check("w3_rd_lat", 64'(lat), 64'd3);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_hold", {21'd0, o_valid, o_ready, o_extra, o_data},
                  {21'd0, 1'b1, 1'b0, 10'h100, 32'h55AA55AA});
        end
        #2 rsp_ready = 1'b1;
        #1 check("bp_dual_fire", {62'd0, o_valid, o_ready}, 64'd3);
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!o_valid && lat < 30) begin lat++; @(negedge clk); end
        check("bp_second", {22'd0, o_extra, o_data}, {22'd0, 10'h2BC, 32'h55AA55AA});
        check("bp_second_lat", 64'(lat), 64'd3);
        @(posedge clk); #1;

        // WAIT=5: reset while a write is still waiting.
        sel = 2'd2;
        do_req(1'b0, 10'd7, 32'h13579BDF, 4'hF, 10'h007, 0, d, r, x, lat);
        check("w5_wr_lat", 64'(lat), 64'(wait_of[2]));
        req_read = 1'b0; req_index = 10'd7; req_data = 32'hFFFFFFFF; req_mask = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        check("mid_accept", {63'd0, o_ready}, 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", {62'd0, o_valid, o_busy}, 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst", {21'd0, o_ready, o_busy, o_valid, o_extra, o_data},
              {21'd0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_quiet", {63'd0, o_valid}, 64'd0);
        end
        @(posedge clk); #1;
        do_req(1'b1, 10'd7, 32'h0, 4'hF, 10'h3C3, 0, d, r, x, lat);
        check("survive_data", {22'd0, x, d}, {22'd0, 10'h3C3, 32'h13579BDF});
        check("survive_lat", 64'(lat), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/n101_icb_responder.md
# n101_icb_responder

Single-outstanding bus responder that terminates the request stream emitted by the peripheral 1-entry request queue (fields read/index/data/mask/extra) and returns one response per request. It owns a word-addressed, byte-maskable storage array, inserts a programmable number of wait states, and holds each response until the initiator accepts it. It sits on the peripheral side of the queue, in front of simple register/SRAM-style peripherals.

## Interface
- AW, 10: index width; array depth is 2**AW words.
- DW, 32: data width; mask width is DW/8.
- XW, 10: extra (tag) width, echoed unchanged.
- WAIT, 0: wait states between accept and response, 0..15.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- io_req_valid  in  1  request present.
- io_req_ready  out  1  responder can accept a request this cycle.
- io_req_bits_read  in  1  1 = read, 0 = write.
- io_req_bits_index  in  AW  word index.
- io_req_bits_data  in  DW  write data.
- io_req_bits_mask  in  DW/8  byte enables; bit i covers data[8i+7:8i].
- io_req_bits_extra  in  XW  tag returned with the response.
- io_rsp_valid  out  1  response present.
- io_rsp_ready  in  1  initiator accepts the response.
- io_rsp_bits_data  out  DW  read data; 0 for writes.
- io_rsp_bits_read  out  1  echo of request read bit.
- io_rsp_bits_extra  out  XW  echo of request extra.
- io_busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- req_fire = io_req_valid & io_req_ready; rsp_fire = io_rsp_valid & io_rsp_ready.
- io_req_ready = (state == IDLE) | (state == RESP & io_rsp_ready).
- On req_fire: latch read, index, data, mask, extra. If WAIT == 0, go to RESP and perform the access on the same edge. Otherwise go to WAIT and load cnt = WAIT.
- WAIT: decrement cnt each cycle. When cnt == 1, perform the access and go to RESP on that edge.
- Access, read: rsp_data <= array[index]. The full word is returned and mask is ignored.
- Access, write: array[index] byte i <= data byte i for each mask[i] = 1. rsp_data <= 0.
- A write with mask = 0 changes no byte but still produces a response.
- RESP: io_rsp_valid = 1. Response fields are stable until rsp_fire.
  - rsp_fire without req_fire: go to IDLE.
  - rsp_fire with req_fire (back-to-back): handle the new request exactly as an acceptance from IDLE.
- io_rsp_bits_data, read and extra are registers and never change while io_rsp_valid = 1 and io_rsp_ready = 0.
- Reset values: state = IDLE, cnt = 0, io_rsp_valid = 0, io_req_ready = 1, io_busy = 0, rsp data/read/extra = 0.
- Reset mid-operation: any pending request is dropped with no response. A write still in WAIT does not reach the array. The array is not reset, and its contents survive reset.
- cnt is 4 bits. No overflow is possible because WAIT ≤ 15 is checked at elaboration.

## Timing
- Request accepted in cycle T: io_rsp_valid rises in cycle T+1+WAIT.
- Throughput with io_rsp_ready held at 1: one response every 1+WAIT cycles.
- WAIT = 0 gives full rate: a new request is accepted every cycle in which the previous response fires.
- Write data is visible to a read accepted in any later cycle. Only one request is outstanding, so no hazard logic is needed.
- No combinational path from io_req_* to io_rsp_*.
- Only path from io_rsp_ready to io_req_ready: a single AND term.

## Structure
- Package n101_icb_pkg holds:
  - state encoding localparams: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  - default widths AW/DW/XW.
- Sub-module n101_bytemask_ram (parameters AW, DW) contains the storage array.
  - Ports: clock, en, we, index, wdata, wmask, rdata.
  - Synchronous read and byte-enabled write.
  - No reset on the array.
- The top level holds the FSM, the wait counter, the request latch and the response registers.

## Test plan
- WAIT=0 basic write/read: write index 5, data 0xDEADBEEF, mask 0xF, extra 0x3A5. Response 1 cycle later has data 0, read 0, extra 0x3A5. Then read index 5 returns 0xDEADBEEF with its own extra.
- Byte mask: after writing 0xDEADBEEF, write 0x11223344 with mask 0x5. A read returns 0xDE22BE44.
- WAIT=3 latency: accept in cycle T, io_rsp_valid first high in T+4. io_req_ready is low in T+1..T+3.
- Backpressure: hold io_rsp_ready = 0 for 6 cycles. Response fields are stable and io_req_ready = 0 throughout. Raising io_rsp_ready with io_req_valid = 1 gives rsp_fire and req_fire in the same cycle.
- Back-to-back (WAIT=0, io_rsp_ready = 1): issue 4 reads of indices 0..3 on consecutive cycles. Responses appear on consecutive cycles in order with matching extra tags.
- Reset mid-op (WAIT=5): write index 7 with 0xFFFFFFFF, assert reset in cycle T+2. io_rsp_valid stays 0 and a later read of index 7 returns the prior value. After reset, io_req_ready = 1 and io_busy = 0.
